line_burst_adapter: RTL

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

---
 rtl/line_adapter_pkg.sv | 21 ++
 rtl/line_burst_adapter.sv | 96 +++++++++
 2 files changed

// File: rtl/line_adapter_pkg.sv
// Shared constants and state encoding for the cache-line to memory-burst adapter.
package line_adapter_pkg;

    localparam int LINE_W_DEF  = 256;
    localparam int BURST_W_DEF = 64;

    // Number of memory beats needed to move one cache line.
    function automatic int beats_of(input int line_w, input int burst_w);
        return line_w / burst_w;
    endfunction

    localparam int BEATS_DEF = beats_of(LINE_W_DEF, BURST_W_DEF);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/line_burst_adapter.sv
// Memory-side responder that splits cache-line writes into bursts and
// assembles read bursts back into a line.
// Optional feature macro: LINE_ADAPTER_ALIGN_EN (forces line-offset bits of
// address_o to zero).
import line_adapter_pkg::*;

module line_burst_adapter #(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = beats_of(LINE_W, BURST_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    state_e                          state;
    logic [CNT_W-1:0]                cnt;
    logic [31:0]                     addr_q;
    logic [BEATS-1:0][BURST_W-1:0]   wr_q;
    logic [BEATS-1:0][BURST_W-1:0]   line_q;

    // Request acceptance, beat sequencing and read-line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wr_q   <= '0;
            line_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Read has priority when both requests arrive together.
                    if (read_i) begin
                        addr_q <= address_i;
                        cnt    <= '0;
                        state  <= RD_BURST;
                    end else if (write_i) begin
                        addr_q <= address_i;
                        wr_q   <= line_i;
                        cnt    <= '0;
                        state  <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_q[cnt] <= burst_i;
                        if (cnt == LAST) state <= DONE;
                        else             cnt   <= cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        if (cnt == LAST) state <= DONE;
                        else             cnt   <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;  // DONE: one-cycle response, then idle
            endcase
        end
    end

    // Outputs are pure functions of state, so reset clears them with the FSM.
    always_comb begin
        burst_o = '0;
        if (state == WR_BURST) burst_o = wr_q[cnt];
    end

    assign read_o  = (state == RD_BURST);
    assign write_o = (state == WR_BURST);
    assign resp_o  = (state == DONE);
    assign line_o  = line_q;

`ifdef LINE_ADAPTER_ALIGN_EN
    localparam int OFF_W = $clog2(LINE_W / 8);
    assign address_o = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
`else
    assign address_o = addr_q;
`endif

endmodule
